serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer: computes a WIDTH-bit sum using one 1-bit full-adder slice (xor/and/or structure) per clock, LSB first.
- Operands are latched into shift registers and a carry flip-flop closes the loop between bit-steps.
- Provides a start/busy/done handshake for upstream control logic.
- Trades WIDTH cycles of latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A; sampled on the accepting edge
- b  input  WIDTH  operand B; sampled on the accepting edge
- cin  input  1  carry-in; sampled on the accepting edge
- busy  output  1  high while the addition is in progress
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  registered result; holds the last completed value
- cout  output  1  registered carry-out of the last completed addition

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry flip-flop and bit counter all cleared.
- Reset mid-operation:
  - The operation is abandoned and no done pulse is produced.
  - Outputs go to reset values immediately.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 on edge E0: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, sum_sr<=0, go to RUN.
  - If start=0: remain in IDLE.
- RUN (busy=1): on each edge:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry <= (a_sr[0]&b_sr[0]) | ((a_sr[0]^b_sr[0])&carry).
  - a_sr and b_sr shift right by one.
  - s shifts into sum_sr MSB; cnt increments.
- RUN exit: on the edge where cnt reaches WIDTH-1 (the WIDTH-th RUN edge, E_WIDTH):
  - sum<=final sum_sr value; cout<=final carry.
  - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally go to IDLE.
- Latency and throughput:
  - done is high in the cycle following edge E_WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start handling:
  - start is ignored in RUN and DONE; it is not queued.
  - A start held high continuously gives one operation per IDLE visit.
- Output stability:
  - sum and cout change only on the edge entering DONE.
  - They hold across subsequent operations until the next completion; there are no intermediate values on the outputs.
- Operand stability: a, b and cin may change freely after the accepting edge.
- WIDTH=1: RUN lasts one edge; done follows in the next cycle.
- Arithmetic: result is (a+b+cin) mod 2^WIDTH; cout is bit WIDTH of the full sum.
- Counter width: $clog2(WIDTH+1) bits, no wrap inside an operation.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), sampled with a and b.
  - When sub=1: b_sr<=~b and carry<=1 (cin ignored); the result is a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b unsigned).
  - When sub=0: addition as above.
- Undefined: port sub is absent and the block performs addition only.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, cin=0, one-cycle start -> busy high 8 cycles; done 1 cycle; sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; sum is unchanged during busy.
- start held high across 3 operations with a=0x55, b=0xAA, cin=0:
  - Each result is sum=0xFF, cout=0.
  - done pulses are spaced exactly 10 cycles apart.
  - No start is accepted in RUN or DONE.
- Assert rst for 1 cycle at RUN bit 4 of a=0x3C, b=0x0C:
  - Outputs immediately 0; no done pulse.
  - Next operation a=0x3C, b=0x0C, cin=0 -> sum=0x48, cout=0.
- WIDTH=1 instance: a=1, b=1, cin=1 -> done 2 cycles after the start edge; sum=1, cout=1.
- SERIAL_ADD_SUB_EN defined:
  - a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1.
  - a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice per clock, LSB first, start/busy/done handshake.
// Define SERIAL_ADD_SUB_EN to add a 'sub' input that selects a-b instead of a+b+cin.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_sr_nx;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             carry;
    logic             carry_nx;
    logic             s;
    logic             last;
    logic [CW-1:0]    cnt;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; cin has no meaning in that mode.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign s         = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_nx  = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
    assign sum_sr_nx = (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
    assign last      = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b_load;
                        carry  <= c_load;
                        cnt    <= '0;
                        sum_sr <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_nx;
                    sum_sr <= sum_sr_nx;
                    // Outputs only move at completion, never mid-operation.
                    if (last) begin
                        sum  <= sum_sr_nx;
                        cout <= carry_nx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances).
// Random operands are checked against plain integer arithmetic.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    logic       sub = 1'b0;
    logic       sub1 = 1'b0;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] last_sum = '0;
    logic       last_cout = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u8 (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub  (sub),
`endif
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u1 (
        .clk  (clk),
        .rst  (rst),
        .start(start1),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub  (sub1),
`endif
        .busy (busy1),
        .done (done1),
        .sum  (sum1),
        .cout (cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b exp all 0",
                     busy, done, sum, cout);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset1 got busy=%b done=%b sum=%b cout=%b exp all 0",
                     busy1, done1, sum1, cout1);
        end
        rst = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        tick();
    endtask

    // One full operation on the WIDTH=8 instance, checking every cycle.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic ts);
        logic [8:0] full;
        if (ts) full = {1'b0, ta} + {1'b0, ~tb} + 9'd1;
        else    full = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        a = ta;
        b = tb;
        cin = tc;
`ifdef SERIAL_ADD_SUB_EN
        sub = ts;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL run_busy k=%0d got busy=%b done=%b exp 1/0",
                         k, busy, done);
            end
            n_checks++;
            if (sum !== last_sum || cout !== last_cout) begin
                n_fail++;
                $display("FAIL run_hold k=%0d got %h/%b exp %h/%b",
                         k, sum, cout, last_sum, last_cout);
            end
            if (k != 7) tick();
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse got done=%b busy=%b exp 1/0", done, busy);
        end
        n_checks++;
        if (sum !== full[7:0] || cout !== full[8]) begin
            n_fail++;
            $display("FAIL result a=%h b=%h c=%b s=%b got %h/%b exp %h/%b",
                     ta, tb, tc, ts, sum, cout, full[7:0], full[8]);
        end
        last_sum  = full[7:0];
        last_cout = full[8];
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after got done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_directed();
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back();
        int seen;
        int prev;
        seen = 0;
        prev = -1;
        a = 8'h55;
        b = 8'hAA;
        cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        start = 1'b1;
        for (int cyc = 0; cyc < 60 && seen < 3; cyc++) begin
            tick();
            if (done === 1'b1) begin
                seen++;
                n_checks++;
                if (sum !== 8'hFF || cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result got %h/%b exp ff/0", sum, cout);
                end
                if (prev >= 0) begin
                    n_checks++;
                    if (cyc - prev != 10) begin
                        n_fail++;
                        $display("FAIL b2b_spacing got %0d exp 10", cyc - prev);
                    end
                end
                prev = cyc;
            end
        end
        start = 1'b0;
        n_checks++;
        if (seen != 3) begin
            n_fail++;
            $display("FAIL b2b_count got %0d exp 3", seen);
        end
        last_sum  = 8'hFF;
        last_cout = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        a = 8'h3C;
        b = 8'h0C;
        cin = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_mid got busy=%b done=%b sum=%h cout=%b exp all 0",
                     busy, done, sum, cout);
        end
        tick();
        rst = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL rst_abandon got activity=1 exp 0");
        end
        run_op(8'h3C, 8'h0C, 1'b0, 1'b0);
    endtask

    task automatic test_width1();
        logic [1:0] full;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                a1 = 1'b1;
                b1 = 1'b1;
                cin1 = 1'b1;
            end else begin
                a1 = 1'($urandom);
                b1 = 1'($urandom);
                cin1 = 1'($urandom);
            end
            full = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            n_checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL w1_busy got busy=%b done=%b exp 1/0", busy1, done1);
            end
            tick();
            n_checks++;
            if (done1 !== 1'b1 || sum1 !== full[0] || cout1 !== full[1]) begin
                n_fail++;
                $display("FAIL w1_result got done=%b %b/%b exp 1 %b/%b",
                         done1, sum1, cout1, full[0], full[1]);
            end
            tick();
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        run_op(8'h10, 8'h01, 1'b0, 1'b1);
        run_op(8'h01, 8'h02, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_width1();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
